// File: rtl/bus_timer_responder_if.sv
// Bus interface between the CPU data-bus initiator and the timer responder.
interface bus_timer_responder_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;

   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic [BE_W-1:0]   byteenable;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              irq;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata, irq
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata, irq
   );
endinterface

// File: rtl/bus_timer_responder.sv
// Memory-mapped 32-bit timer responder with fixed wait states, compare-match,
// overflow and protocol-error flags, and a level interrupt.
// Optional feature macro: BUS_TIMER_PRESCALER_EN (PRESCALE register at offset 4).
module bus_timer_responder #(
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter int unsigned STALL_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   bus_timer_responder_if.slave  bus
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SCNT_W = 4;
   localparam logic [SCNT_W-1:0] STALL_LIM = SCNT_W'(STALL_CYCLES);

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_COUNT    = 3'd1;
   localparam logic [2:0] OFF_COMPARE  = 3'd2;
   localparam logic [2:0] OFF_STATUS   = 3'd3;
   localparam logic [2:0] OFF_PRESCALE = 3'd4;

   logic [2:0]        ctrl_q, ctrl_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic [DATA_W-1:0] compare_q, compare_d;
   logic [2:0]        status_q, status_d;
   logic [SCNT_W-1:0] scnt_q, scnt_d;
`ifdef BUS_TIMER_PRESCALER_EN
   logic [DATA_W-1:0] prescale_q, prescale_d;
   logic [DATA_W-1:0] pcnt_q, pcnt_d;
`endif

   logic              sel_c, req_c, wait_c, done_c;
   logic              err_c, wr_c, rd_c, tick_c;
   logic [2:0]        off_c;
   logic              match_set, ovf_set;
   logic [2:0]        stat_clr;
   logic [DATA_W-1:0] rdata_c;
   logic [1:0]        unused_addr_c;

   // Byte-lane merge of a write into a full register word.
   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] wdat,
                                                     input logic [3:0]        be);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = be[i] ? wdat[8*i +: 8] : old_v[8*i +: 8];
      end
      return r;
   endfunction

   // Decode and handshake; everything is gated by reset so waitrequest drops at once.
   assign unused_addr_c = bus.address[1:0];
   assign sel_c  = (bus.address[31:5] == BASE_ADDR[31:5]);
   assign off_c  = bus.address[4:2];
   assign req_c  = reset & sel_c & (bus.read | bus.write);
   assign wait_c = req_c & (scnt_q < STALL_LIM);
   assign done_c = req_c & ~wait_c;
   assign err_c  = done_c & bus.read & bus.write;
   assign wr_c   = done_c & bus.write & ~bus.read;
   assign rd_c   = done_c & bus.read & ~bus.write;

`ifdef BUS_TIMER_PRESCALER_EN
   assign tick_c = ctrl_q[0] & (pcnt_q == prescale_q);
`else
   assign tick_c = ctrl_q[0];
`endif

   // Next-state: stall counter, timer, flags and register writes.
   always_comb begin
      ctrl_d    = ctrl_q;
      count_d   = count_q;
      compare_d = compare_q;
      status_d  = status_q;
      scnt_d    = '0;
      match_set = 1'b0;
      ovf_set   = 1'b0;
      stat_clr  = '0;
`ifdef BUS_TIMER_PRESCALER_EN
      prescale_d = prescale_q;
      pcnt_d     = pcnt_q;
      if (!ctrl_q[0] || tick_c) pcnt_d = '0;
      else                      pcnt_d = pcnt_q + DATA_W'(1);
`endif

      if (wait_c) scnt_d = scnt_q + SCNT_W'(1);

      if (tick_c) begin
         if (count_q == compare_q) begin
            match_set = 1'b1;
            ovf_set   = (count_q == '1);
            count_d   = ctrl_q[1] ? '0 : count_q + DATA_W'(1);
         end else if (count_q == '1) begin
            ovf_set = 1'b1;
            count_d = '0;
         end else begin
            count_d = count_q + DATA_W'(1);
         end
      end

      if (wr_c) begin
         case (off_c)
            OFF_CTRL:    if (bus.byteenable[0]) ctrl_d = bus.writedata[2:0];
            OFF_COUNT:   count_d   = merge_bytes(count_q, bus.writedata, bus.byteenable);
            OFF_COMPARE: compare_d = merge_bytes(compare_q, bus.writedata, bus.byteenable);
            OFF_STATUS:  stat_clr  = {3{bus.byteenable[0]}} & bus.writedata[2:0];
`ifdef BUS_TIMER_PRESCALER_EN
            OFF_PRESCALE: begin
               prescale_d = merge_bytes(prescale_q, bus.writedata, bus.byteenable);
               pcnt_d     = '0;
            end
`endif
            default: ;
         endcase
      end

      status_d = (status_q & ~stat_clr) | {err_c, ovf_set, match_set};
   end

   // Read mux, only driven during a completing plain read.
   always_comb begin
      rdata_c = '0;
      if (rd_c) begin
         case (off_c)
            OFF_CTRL:     rdata_c = DATA_W'(ctrl_q);
            OFF_COUNT:    rdata_c = count_q;
            OFF_COMPARE:  rdata_c = compare_q;
            OFF_STATUS:   rdata_c = DATA_W'(status_q);
`ifdef BUS_TIMER_PRESCALER_EN
            OFF_PRESCALE: rdata_c = prescale_q;
`endif
            default:      rdata_c = '0;
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_q    <= '0;
         count_q   <= '0;
         compare_q <= '1;
         status_q  <= '0;
         scnt_q    <= '0;
`ifdef BUS_TIMER_PRESCALER_EN
         prescale_q <= '0;
         pcnt_q     <= '0;
`endif
      end else begin
         ctrl_q    <= ctrl_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         status_q  <= status_d;
         scnt_q    <= scnt_d;
`ifdef BUS_TIMER_PRESCALER_EN
         prescale_q <= prescale_d;
         pcnt_q     <= pcnt_d;
`endif
      end
   end

   assign bus.waitrequest = wait_c;
   assign bus.readdata    = rdata_c;
   assign bus.irq         = status_q[0] & ctrl_q[2];
endmodule

// File: tb/tb_bus_timer_responder.sv
// Directed bench for bus_timer_responder with three wait states.
module tb_bus_timer_responder;
   localparam logic [31:0] BASE   = 32'h1000_0000;
   localparam int unsigned STALLS = 3;
   localparam logic [31:0] A_CTRL = BASE + 32'h0;
   localparam logic [31:0] A_CNT  = BASE + 32'h4;
   localparam logic [31:0] A_CMP  = BASE + 32'h8;
   localparam logic [31:0] A_STAT = BASE + 32'hC;
   localparam logic [31:0] A_PRE  = BASE + 32'h10;
   localparam logic [31:0] A_RSV  = BASE + 32'h18;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   bus_timer_responder_if bus();

   bus_timer_responder #(.BASE_ADDR(BASE), .STALL_CYCLES(STALLS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // One bus transfer: present at negedge, count stall cycles, capture readdata
   // in the completing cycle, release after the completing edge.
   task automatic xfer(input logic [31:0] addr, input logic rd, input logic wr,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rdata, output int waits);
      @(negedge clk);
      bus.address = addr; bus.read = rd; bus.write = wr;
      bus.writedata = wd; bus.byteenable = be;
      waits = 0;
      #1;
      while (bus.waitrequest === 1'b1 && waits < 20) begin
         waits++;
         @(negedge clk);
         #1;
      end
      rdata = bus.readdata;
      @(posedge clk);
      #1;
      bus.read = 1'b0; bus.write = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] d; int w;
      xfer(addr, 1'b0, 1'b1, wd, be, d, w);
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] d);
      int w;
      xfer(addr, 1'b1, 1'b0, 32'h0, 4'hF, d, w);
   endtask

   task automatic test_reset;
      logic [31:0] d;
      total++; if (bus.waitrequest !== 1'b0) begin bad++; $display("FAIL rst_wait got=%b exp=0", bus.waitrequest); end
      total++; if (bus.readdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.readdata); end
      total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", bus.irq); end
      rd(A_CTRL, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_ctrl got=%h exp=0", d); end
      rd(A_CNT, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_count got=%h exp=0", d); end
      rd(A_CMP, d);
      total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rst_compare got=%h exp=ffffffff", d); end
      rd(A_STAT, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_status got=%h exp=0", d); end
      rd(A_PRE, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_prescale got=%h exp=0", d); end
   endtask

   task automatic test_stall;
      logic [31:0] d; int w;
      xfer(A_CMP, 1'b0, 1'b1, 32'h0000_0010, 4'hF, d, w);
      total++; if (w !== 3) begin bad++; $display("FAIL stall_write got=%0d exp=3", w); end
      xfer(A_CMP, 1'b1, 1'b0, 32'h0, 4'hF, d, w);
      total++; if (w !== 3) begin bad++; $display("FAIL stall_read got=%0d exp=3", w); end
      total++; if (d !== 32'h0000_0010) begin bad++; $display("FAIL stall_rdata got=%h exp=00000010", d); end
   endtask

   task automatic test_match_irq;
      logic [31:0] d;
      wr(A_CNT, 32'h0, 4'hF);
      wr(A_CMP, 32'h5, 4'hF);
      wr(A_STAT, 32'h7, 4'hF);
      wr(A_CTRL, 32'h5, 4'hF);
      repeat (5) @(posedge clk);
      #1;
      total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", bus.irq); end
      @(posedge clk);
      #1;
      total++; if (bus.irq !== 1'b1) begin bad++; $display("FAIL irq_match got=%b exp=1", bus.irq); end
      rd(A_STAT, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL match_status got=%h exp=1", d); end
      wr(A_STAT, 32'h1, 4'h1);
      #1;
      total++; if (bus.irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", bus.irq); end
      wr(A_CTRL, 32'h0, 4'hF);
   endtask

   task automatic test_overflow;
      logic [31:0] d;
      wr(A_CMP, 32'h1000, 4'hF);
      wr(A_STAT, 32'h7, 4'hF);
      wr(A_CNT, 32'hFFFF_FFFE, 4'hF);
      wr(A_CTRL, 32'h1, 4'hF);
      rd(A_CNT, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL ovf_count got=%h exp=1", d); end
      rd(A_STAT, d);
      total++; if (d !== 32'h2) begin bad++; $display("FAIL ovf_status got=%h exp=2", d); end
      wr(A_CTRL, 32'h0, 4'hF);
   endtask

   task automatic test_byte_merge;
      logic [31:0] d;
      wr(A_CNT, 32'hAABB_CCDD, 4'hF);
      wr(A_CNT, 32'h1122_3344, 4'b0101);
      rd(A_CNT, d);
      total++; if (d !== 32'hAA22_CC44) begin bad++; $display("FAIL byte_merge got=%h exp=aa22cc44", d); end
      wr(A_CTRL, 32'hFFFF_FFF8, 4'hF);
      rd(A_CTRL, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL ctrl_unused got=%h exp=0", d); end
   endtask

   task automatic test_protocol_error;
      logic [31:0] d; int w;
      wr(A_STAT, 32'h7, 4'hF);
      wr(A_CTRL, 32'h4, 4'hF);
      xfer(A_CTRL, 1'b1, 1'b1, 32'h7, 4'hF, d, w);
      total++; if (w !== 3) begin bad++; $display("FAIL err_wait got=%0d exp=3", w); end
      total++; if (d !== 32'h0) begin bad++; $display("FAIL err_rdata got=%h exp=0", d); end
      rd(A_CTRL, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL err_ctrl got=%h exp=4", d); end
      rd(A_STAT, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL err_status got=%h exp=4", d); end
      xfer(BASE + 32'h40, 1'b0, 1'b1, 32'h0, 4'hF, d, w);
      total++; if (w !== 0) begin bad++; $display("FAIL unsel_wait got=%0d exp=0", w); end
      xfer(BASE + 32'h40, 1'b1, 1'b0, 32'h0, 4'hF, d, w);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL unsel_rdata got=%h exp=0", d); end
      rd(A_CTRL, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL unsel_ctrl got=%h exp=4", d); end
   endtask

   task automatic test_w1c_reserved;
      logic [31:0] d;
      wr(A_STAT, 32'h7, 4'h0);
      rd(A_STAT, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL w1c_nolane got=%h exp=4", d); end
      wr(A_STAT, 32'h3, 4'h1);
      rd(A_STAT, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL w1c_other got=%h exp=4", d); end
      wr(A_STAT, 32'h4, 4'h1);
      rd(A_STAT, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_err got=%h exp=0", d); end
      wr(A_RSV, 32'hFFFF_FFFF, 4'hF);
      rd(A_RSV, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reserved got=%h exp=0", d); end
`ifndef BUS_TIMER_PRESCALER_EN
      wr(A_PRE, 32'h12, 4'hF);
      rd(A_PRE, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL off4_reserved got=%h exp=0", d); end
`endif
   endtask

   task automatic test_abandon;
      logic [31:0] d; int w;
      @(negedge clk);
      bus.address = A_CMP; bus.write = 1'b1; bus.read = 1'b0;
      bus.writedata = 32'hDEAD_BEEF; bus.byteenable = 4'hF;
      @(negedge clk);
      bus.write = 1'b0;
      xfer(A_CMP, 1'b1, 1'b0, 32'h0, 4'hF, d, w);
      total++; if (d !== 32'h1000) begin bad++; $display("FAIL abandon_cmp got=%h exp=00001000", d); end
      total++; if (w !== 3) begin bad++; $display("FAIL abandon_scnt got=%0d exp=3", w); end
   endtask

   task automatic test_auto_reload;
      logic [31:0] d;
      wr(A_CMP, 32'h2, 4'hF);
      wr(A_CNT, 32'h0, 4'hF);
      wr(A_STAT, 32'h7, 4'hF);
      wr(A_CTRL, 32'h3, 4'hF);
      rd(A_CNT, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reload_a got=%h exp=0", d); end
      rd(A_CNT, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL reload_b got=%h exp=1", d); end
      rd(A_STAT, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL reload_status got=%h exp=1", d); end
      wr(A_CTRL, 32'h0, 4'hF);
   endtask

`ifdef BUS_TIMER_PRESCALER_EN
   task automatic test_prescaler;
      logic [31:0] d;
      wr(A_PRE, 32'h3, 4'hF);
      wr(A_CNT, 32'h0, 4'hF);
      wr(A_CMP, 32'h1000, 4'hF);
      wr(A_CTRL, 32'h1, 4'hF);
      rd(A_CNT, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL pre_a got=%h exp=0", d); end
      rd(A_CNT, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL pre_b got=%h exp=1", d); end
      @(posedge clk);
      rd(A_CNT, d);
      total++; if (d !== 32'h3) begin bad++; $display("FAIL pre_c got=%h exp=3", d); end
      rd(A_PRE, d);
      total++; if (d !== 32'h3) begin bad++; $display("FAIL pre_reg got=%h exp=3", d); end
   endtask
`endif

   task automatic test_reset_mid_stall;
      logic [31:0] d;
      wr(A_CTRL, 32'h5, 4'hF);
      wr(A_CMP, 32'h0000_0100, 4'hF);
      @(negedge clk);
      bus.address = A_CTRL; bus.read = 1'b1; bus.write = 1'b0;
      #1;
      total++; if (bus.waitrequest !== 1'b1) begin bad++; $display("FAIL mid_wait got=%b exp=1", bus.waitrequest); end
      #2;
      reset = 1'b0;
      #1;
      total++; if (bus.waitrequest !== 1'b0) begin bad++; $display("FAIL rst_drop got=%b exp=0", bus.waitrequest); end
      total++; if (bus.readdata !== 32'h0) begin bad++; $display("FAIL rst_drop_rdata got=%h exp=0", bus.readdata); end
      bus.read = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      rd(A_CTRL, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL post_ctrl got=%h exp=0", d); end
      rd(A_CMP, d);
      total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL post_cmp got=%h exp=ffffffff", d); end
      rd(A_PRE, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL post_pre got=%h exp=0", d); end
   endtask

   initial begin
      bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
      bus.writedata = '0; bus.byteenable = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      test_reset();
      test_stall();
      test_match_irq();
      test_overflow();
      test_byte_merge();
      test_protocol_error();
      test_w1c_reserved();
      test_abandon();
      test_auto_reload();
`ifdef BUS_TIMER_PRESCALER_EN
      test_prescaler();
`endif
      test_reset_mid_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
